// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: single-outstanding data-SRAM sequencer between EXE and MEM.
// Turns an EXE load/store into a req/addr_ok/data_ok transaction, produces
// the EXE and MEM ready-go gates, and returns the aligned, extended load data.
module data_sram_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic        exe_dram_re,
  input  logic        exe_dram_we,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_wdata,
  input  logic [1:0]  exe_wdram_num,
  input  logic [1:0]  exe_rdram_num,
  input  logic        exe_rdram_need_signed_extend,
  input  logic        ms_allowin,
  input  logic        flush,
  output logic        exe_ready_go,
  output logic        mem_ready_go,
  output logic [31:0] mem_load_result,
  output logic        ale,
  output logic        timeout,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sext_q, sext_d;
  logic [31:0] result_q, result_d;

  logic        access, misaligned, can_accept, start, busy, wd_hit;
  logic [1:0]  acc_size;
  logic [31:0] shifted, load_fmt;

  // Decode the EXE request: size, alignment and whether a new access may start.
  always_comb begin
    access     = exe_valid & (exe_dram_re | exe_dram_we);
    acc_size   = exe_dram_we ? exe_wdram_num : exe_rdram_num;
    misaligned = ((acc_size == 2'd1) & exe_addr[0]) |
                 (acc_size[1] & (exe_addr[1:0] != 2'b00));
    // DONE hands the slot over to a new access in the same cycle WB takes the result.
    can_accept = (state_q == S_IDLE) | ((state_q == S_DONE) & ms_allowin);
    start      = can_accept & ~flush & access & ~misaligned;
    ale        = can_accept & ~flush & access & misaligned;
    busy       = (state_q == S_REQ) | (state_q == S_WAIT);
    // The watchdog fires in the cycle that would make the REQ+WAIT cycle count reach the limit.
    wd_hit     = (WAIT_LIMIT != 0) & busy & ((cnt_q + 32'd1) == WAIT_LIMIT);
    timeout    = timeout_q | wd_hit;
  end

  // Align and extend the raw read data according to the latched access.
  always_comb begin
    shifted = data_sram_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_fmt = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_fmt = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // Transaction state machine, request latching and watchdog next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cancel_d     = cancel_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    sext_d       = sext_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q | wd_hit;
    exe_ready_go = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
        else       exe_ready_go = 1'b1;
      end
      S_REQ: begin
        if (data_sram_addr_ok) begin
          // The handshake wins over a simultaneous flush; the response is drained later.
          exe_ready_go = 1'b1;
          cancel_d     = flush;
          state_d      = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q | flush) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DONE;
            result_d = wr_q ? 32'd0 : load_fmt;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      default: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (ms_allowin) begin
          if (start) begin
            state_d = S_REQ;
          end else begin
            state_d      = S_IDLE;
            exe_ready_go = 1'b1;
          end
        end
      end
    endcase

    if (start) begin
      addr_d = exe_addr;
      size_d = acc_size;
      wr_d   = exe_dram_we;
      sext_d = exe_rdram_need_signed_extend;
      case (acc_size)
        2'd0: begin
          wstrb_d = 4'b0001 << exe_addr[1:0];
          wdata_d = {4{exe_wdata[7:0]}};
        end
        2'd1: begin
          wstrb_d = 4'b0011 << exe_addr[1:0];
          wdata_d = {2{exe_wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = exe_wdata;
        end
      endcase
      if (!exe_dram_we) wstrb_d = 4'b0000;
      cnt_d = 32'd0;
    end else if (busy & ~timeout_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      state_q   <= S_IDLE;
      cancel_q  <= 1'b0;
      cnt_q     <= 32'd0;
      timeout_q <= 1'b0;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      wr_q      <= 1'b0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      sext_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cancel_q  <= cancel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      sext_q    <= sext_d;
      result_q  <= result_d;
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign mem_ready_go    = (state_q == S_DONE);
  assign mem_load_result = result_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed self-checking bench for data_sram_ctrl (WAIT_LIMIT = 4).
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, exe_dram_re, exe_dram_we;
  logic [31:0] exe_addr, exe_wdata;
  logic [1:0]  exe_wdram_num, exe_rdram_num;
  logic        exe_rdram_need_signed_extend;
  logic        ms_allowin, flush;
  logic        exe_ready_go, mem_ready_go, ale, timeout;
  logic [31:0] mem_load_result;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int failures = 0;

  data_sram_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .exe_valid(exe_valid), .exe_dram_re(exe_dram_re), .exe_dram_we(exe_dram_we),
    .exe_addr(exe_addr), .exe_wdata(exe_wdata),
    .exe_wdram_num(exe_wdram_num), .exe_rdram_num(exe_rdram_num),
    .exe_rdram_need_signed_extend(exe_rdram_need_signed_extend),
    .ms_allowin(ms_allowin), .flush(flush),
    .exe_ready_go(exe_ready_go), .mem_ready_go(mem_ready_go),
    .mem_load_result(mem_load_result), .ale(ale), .timeout(timeout),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_in();
    exe_valid = 0; exe_dram_re = 0; exe_dram_we = 0;
    exe_addr = 0; exe_wdata = 0; exe_wdram_num = 0; exe_rdram_num = 0;
    exe_rdram_need_signed_extend = 0; ms_allowin = 0; flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
  endtask

  task automatic do_reset();
    clr_in();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [1:0] num, input logic sgn);
    exe_valid = 1; exe_dram_re = 1; exe_dram_we = 0;
    exe_addr = a; exe_rdram_num = num; exe_rdram_need_signed_extend = sgn;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (data_sram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", data_sram_req); end
    checks++; if (mem_ready_go !== 1'b0) begin failures++; $display("FAIL reset_mrg: got %b want 0", mem_ready_go); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if ({data_sram_addr, data_sram_wstrb, mem_load_result} !== 68'd0) begin failures++;
      $display("FAIL reset_regs: addr=%h wstrb=%b result=%h want all 0", data_sram_addr, data_sram_wstrb, mem_load_result); end
    checks++; if (exe_ready_go !== 1'b1) begin failures++; $display("FAIL reset_erg_idle: got %b want 1", exe_ready_go); end
  endtask

  // One load with addr_ok in the first REQ cycle and data_ok the cycle after.
  task automatic run_load(input string nm, input logic [31:0] a, input logic [1:0] num,
                          input logic sgn, input logic [31:0] rd, input logic [31:0] exp_res);
    do_reset();
    drive_load(a, num, sgn);
    sample();
    checks++; if (exe_ready_go !== 1'b0 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL %s_issue: erg=%b req=%b want 0 0", nm, exe_ready_go, data_sram_req); end
    tick();
    data_sram_addr_ok = 1;
    sample();
    checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== a || data_sram_size !== num ||
                  data_sram_wr !== 1'b0 || data_sram_wstrb !== 4'b0000 || exe_ready_go !== 1'b1) begin failures++;
      $display("FAIL %s_req: req=%b addr=%h size=%0d wr=%b wstrb=%b erg=%b want 1 %h %0d 0 0000 1",
               nm, data_sram_req, data_sram_addr, data_sram_size, data_sram_wr, data_sram_wstrb, exe_ready_go, a, num); end
    tick();
    clr_in();
    data_sram_data_ok = 1; data_sram_rdata = rd;
    sample();
    checks++; if (mem_ready_go !== 1'b0 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL %s_wait: mrg=%b req=%b want 0 0", nm, mem_ready_go, data_sram_req); end
    tick();
    clr_in();
    data_sram_rdata = 32'hDEAD_BEEF;
    sample();
    checks++; if (mem_ready_go !== 1'b1 || mem_load_result !== exp_res) begin failures++;
      $display("FAIL %s_done: mrg=%b result=%h want 1 %h", nm, mem_ready_go, mem_load_result, exp_res); end
    tick();
    sample();
    checks++; if (mem_ready_go !== 1'b1 || mem_load_result !== exp_res) begin failures++;
      $display("FAIL %s_hold: mrg=%b result=%h want 1 %h", nm, mem_ready_go, mem_load_result, exp_res); end
    ms_allowin = 1;
    tick();
    ms_allowin = 0;
    sample();
    checks++; if (mem_ready_go !== 1'b0 || timeout !== 1'b0) begin failures++;
      $display("FAIL %s_idle: mrg=%b timeout=%b want 0 0", nm, mem_ready_go, timeout); end
  endtask

  task automatic test_loads();
    run_load("ld_word", 32'h0000_1000, 2'd2, 1'b0, 32'h8899_AABB, 32'h8899_AABB);
    run_load("ld_sbyte", 32'h0000_1003, 2'd0, 1'b1, 32'h8011_2233, 32'hFFFF_FF80);
    run_load("ld_uhalf", 32'h0000_1002, 2'd1, 1'b0, 32'h8011_2233, 32'h0000_8011);
    run_load("ld_shalf", 32'h0000_1000, 2'd1, 1'b1, 32'h8011_A233, 32'hFFFF_A233);
  endtask

  task automatic test_store();
    do_reset();
    exe_valid = 1; exe_dram_we = 1; exe_addr = 32'h0000_2002;
    exe_wdata = 32'h1234_ABCD; exe_wdram_num = 2'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      exe_addr = 32'h0000_5555 + i;  // EXE changes must not leak into the held request
      sample();
      checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h0000_2002 || data_sram_wstrb !== 4'b1100 ||
                    data_sram_wdata !== 32'hABCD_ABCD || data_sram_size !== 2'd1 || data_sram_wr !== 1'b1 ||
                    exe_ready_go !== 1'b0) begin failures++;
        $display("FAIL st_hold%0d: req=%b addr=%h wstrb=%b wdata=%h size=%0d wr=%b erg=%b want 1 00002002 1100 abcdabcd 1 1 0",
                 i, data_sram_req, data_sram_addr, data_sram_wstrb, data_sram_wdata, data_sram_size, data_sram_wr, exe_ready_go); end
      tick();
    end
    data_sram_addr_ok = 1;
    sample();
    checks++; if (exe_ready_go !== 1'b1 || data_sram_req !== 1'b1) begin failures++;
      $display("FAIL st_addr_ok: erg=%b req=%b want 1 1", exe_ready_go, data_sram_req); end
    tick();
    clr_in();
    data_sram_data_ok = 1; data_sram_rdata = 32'hFFFF_FFFF;
    tick();
    clr_in();
    sample();
    checks++; if (mem_ready_go !== 1'b1 || mem_load_result !== 32'd0) begin failures++;
      $display("FAIL st_done: mrg=%b result=%h want 1 00000000", mem_ready_go, mem_load_result); end
    ms_allowin = 1;
    tick();
    clr_in();
  endtask

  task automatic test_byte_store();
    do_reset();
    exe_valid = 1; exe_dram_we = 1; exe_addr = 32'h0000_2001;
    exe_wdata = 32'h1234_56A7; exe_wdram_num = 2'd0;
    tick();
    clr_in();
    sample();
    checks++; if (data_sram_wstrb !== 4'b0010 || data_sram_wdata !== 32'hA7A7_A7A7 || data_sram_size !== 2'd0) begin failures++;
      $display("FAIL st_byte: wstrb=%b wdata=%h size=%0d want 0010 a7a7a7a7 0", data_sram_wstrb, data_sram_wdata, data_sram_size); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_load(32'h0000_1000, 2'd2, 1'b0);
    tick();
    data_sram_addr_ok = 1;
    tick();
    clr_in();
    data_sram_data_ok = 1; data_sram_rdata = 32'h1111_2222;
    tick();
    clr_in();
    ms_allowin = 1;
    drive_load(32'h0000_3004, 2'd2, 1'b0);
    sample();
    checks++; if (mem_ready_go !== 1'b1 || exe_ready_go !== 1'b0 || mem_load_result !== 32'h1111_2222) begin failures++;
      $display("FAIL b2b_done: mrg=%b erg=%b result=%h want 1 0 11112222", mem_ready_go, exe_ready_go, mem_load_result); end
    tick();
    ms_allowin = 0;
    data_sram_addr_ok = 1;
    sample();
    checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h0000_3004 || mem_ready_go !== 1'b0) begin failures++;
      $display("FAIL b2b_req: req=%b addr=%h mrg=%b want 1 00003004 0", data_sram_req, data_sram_addr, mem_ready_go); end
    tick();
    clr_in();
    data_sram_data_ok = 1; data_sram_rdata = 32'h0102_0304;
    tick();
    clr_in();
    sample();
    checks++; if (mem_ready_go !== 1'b1 || mem_load_result !== 32'h0102_0304) begin failures++;
      $display("FAIL b2b_result: mrg=%b result=%h want 1 01020304", mem_ready_go, mem_load_result); end
  endtask

  task automatic test_ale();
    do_reset();
    drive_load(32'h0000_1001, 2'd2, 1'b0);
    sample();
    checks++; if (ale !== 1'b1 || exe_ready_go !== 1'b1 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL ale_word: ale=%b erg=%b req=%b want 1 1 0", ale, exe_ready_go, data_sram_req); end
    tick();
    exe_addr = 32'h0000_1003; exe_rdram_num = 2'd1;
    sample();
    checks++; if (ale !== 1'b1 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL ale_half: ale=%b req=%b want 1 0", ale, data_sram_req); end
    tick();
    clr_in();
    sample();
    checks++; if (ale !== 1'b0 || data_sram_req !== 1'b0 || exe_ready_go !== 1'b1) begin failures++;
      $display("FAIL ale_after: ale=%b req=%b erg=%b want 0 0 1", ale, data_sram_req, exe_ready_go); end
  endtask

  task automatic test_flush();
    // Flush while waiting for data: response arrives two cycles later and is discarded.
    do_reset();
    drive_load(32'h0000_1000, 2'd2, 1'b0);
    tick();
    data_sram_addr_ok = 1;
    tick();
    clr_in();
    flush = 1;
    tick();
    clr_in();
    tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h5A5A_5A5A;
    tick();
    clr_in();
    sample();
    checks++; if (mem_ready_go !== 1'b0 || data_sram_req !== 1'b0 || exe_ready_go !== 1'b1) begin failures++;
      $display("FAIL flush_wait: mrg=%b req=%b erg=%b want 0 0 1", mem_ready_go, data_sram_req, exe_ready_go); end
    // Flush together with addr_ok: handshake completes, then the response is drained.
    do_reset();
    drive_load(32'h0000_1000, 2'd2, 1'b0);
    tick();
    data_sram_addr_ok = 1; flush = 1;
    sample();
    checks++; if (exe_ready_go !== 1'b1) begin failures++;
      $display("FAIL flush_req_erg: erg=%b want 1", exe_ready_go); end
    tick();
    clr_in();
    data_sram_data_ok = 1;
    tick();
    clr_in();
    sample();
    checks++; if (mem_ready_go !== 1'b0 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL flush_req_drain: mrg=%b req=%b want 0 0", mem_ready_go, data_sram_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive_load(32'h0000_1000, 2'd2, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      sample();
      checks++; if (timeout !== (i == 4) || data_sram_req !== 1'b1) begin failures++;
        $display("FAIL timeout_req%0d: timeout=%b req=%b want %0d 1", i, timeout, data_sram_req, (i == 4)); end
      tick();
    end
    flush = 1;
    tick();
    clr_in();
    tick(); tick();
    sample();
    checks++; if (timeout !== 1'b1 || data_sram_req !== 1'b0) begin failures++;
      $display("FAIL timeout_sticky: timeout=%b req=%b want 1 0", timeout, data_sram_req); end
    do_reset();
    sample();
    checks++; if (timeout !== 1'b0) begin failures++;
      $display("FAIL timeout_clear: timeout=%b want 0", timeout); end
  endtask

  initial begin
    clr_in();
    resetn = 0;
    test_reset();
    test_loads();
    test_store();
    test_byte_store();
    test_back_to_back();
    test_ale();
    test_flush();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Data-SRAM access sequencer between the EXE stage and the EXE→MEM pipeline register. It converts EXE load/store intent into a single-outstanding SRAM-like request/response transaction and byte-lane strobes. It generates `exe_ready_go`, which gates the EXE→MEM register update, and `mem_ready_go`, which gates MEM→WB. It also returns the aligned, extended load result.

## Interface
- `WAIT_LIMIT`, 0, cycles a transaction may spend in REQ+WAIT before sticky `timeout` sets; 0 disables the watchdog.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `exe_valid`  in  1  EXE holds a valid instruction.
- `exe_dram_re` / `exe_dram_we`  in  1 / 1  load / store. Both high is illegal.
- `exe_addr`  in  32  effective address.
- `exe_wdata`  in  32  store data, low-aligned.
- `exe_wdram_num` / `exe_rdram_num`  in  2 / 2  access size: 0 = byte, 1 = half, 2 = word.
- `exe_rdram_need_signed_extend`  in  1  load is signed (else zero-extend).
- `ms_allowin`  in  1  WB accepts the MEM instruction this cycle.
- `flush`  in  1  cancel in-flight access (exception/ertn).
- `exe_ready_go`  out  1  EXE may advance this cycle.
- `mem_ready_go`  out  1  MEM result complete.
- `mem_load_result`  out  32  formatted load data.
- `ale`  out  1  one-cycle pulse: misaligned access detected, no request issued.
- `timeout`  out  1  sticky watchdog flag.
- `data_sram_req`, `data_sram_wr`  out  1, 1  request valid, write.
- `data_sram_size`  out  2  0 / 1 / 2.
- `data_sram_wstrb`  out  4  byte enables (0 for loads).
- `data_sram_addr`, `data_sram_wdata`  out  32, 32.
- `data_sram_addr_ok`, `data_sram_data_ok`  in  1, 1  address accepted / response valid.
- `data_sram_rdata`  in  32  read data.

## Operation
- Access = `exe_valid & (exe_dram_re | exe_dram_we)`. Size = `wdram_num` for stores, `rdram_num` for loads.
- Misaligned: half with `addr[0]`, or word with `addr[1:0]` nonzero. This pulses `ale`, sets `exe_ready_go` = 1 and issues no request. State is unchanged.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - Aligned access: latch addr, size, wstrb, wdata, ext info; go to REQ. `exe_ready_go` = 0.
    - Non-memory instruction: `exe_ready_go` = 1.
  - REQ: `data_sram_req` = 1, with all request outputs held stable.
    - On `addr_ok`: `exe_ready_go` = 1 this cycle; go to WAIT.
    - On `flush` without `addr_ok`: go to IDLE. No `exe_ready_go`.
  - WAIT:
    - On `data_ok`: capture `rdata`; go to DONE, or to IDLE if the cancel bit is set.
    - `flush` sets the cancel bit and keeps the state (the response is drained and discarded).
  - DONE: `mem_ready_go` = 1; `mem_load_result` is held.
    - On `ms_allowin`: go to IDLE.
    - If `ms_allowin` and EXE presents an aligned access in the same cycle: go directly to REQ and latch the new access. A non-memory EXE instruction gets `exe_ready_go` = 1.
    - `flush` → IDLE.
- Store strobes:
  - wstrb: byte = `4'b0001 << addr[1:0]`, half = `4'b0011 << addr[1:0]`, word = `4'b1111`.
  - wdata: byte = `{4{wdata[7:0]}}`, half = `{2{wdata[15:0]}}`, word = as-is.
- Load format: `rdata >> (8*addr[1:0])`, then sign- or zero-extend from bit 7 (byte) or 15 (half); word passes through.
- Stores also wait for `data_ok` (write ack). Their `mem_load_result` = 0.
- Watchdog: counter clears on entering REQ and increments in REQ/WAIT. When it equals `WAIT_LIMIT` (≠0), `timeout` = 1 until reset.
- `data_ok` in IDLE/REQ/DONE is ignored. `flush` in IDLE suppresses latching that cycle.

## Timing
- Reset (`resetn` = 0 at posedge): state IDLE, cancel = 0, counter = 0, `timeout` = 0. All registered outputs = 0; `data_sram_req` = 0.
- Issue latency: access seen in cycle N → `data_sram_req` high in N+1.
- `exe_ready_go` is combinational with `addr_ok`.
- Earliest `data_ok` is the cycle after `addr_ok`. DONE (`mem_ready_go`) follows one cycle after `data_ok`.
- Minimum load latency: EXE cycle N, result valid cycle N+3.
- Simultaneous `addr_ok` & `flush` in REQ: the handshake wins → WAIT with cancel = 1.
- Reset mid-transaction returns to IDLE; late responses are ignored.

## Test plan
- Word load, addr 0x1000, `addr_ok` in first REQ cycle, `data_ok` next cycle, rdata 0x8899AABB → `mem_ready_go` at N+3, result 0x8899AABB.
- Signed byte load, addr 0x1003, rdata 0x80112233 → result 0xFFFFFF80. Unsigned half load, addr 0x1002 → 0x00008011.
- Half store, addr 0x2002, wdata 0x1234ABCD → wstrb 4'b1100, wdata 0xABCDABCD, size 1. `addr_ok` held off 3 cycles → req, addr and wstrb stable throughout.
- Word load, addr 0x1001 → `ale` pulse, no `data_sram_req`, `exe_ready_go` = 1.
- Flush in WAIT, `data_ok` 2 cycles later → no `mem_ready_go`, return to IDLE. Flush with `addr_ok` in REQ → same drain.
- `WAIT_LIMIT` = 4, `addr_ok` never asserted → `timeout` = 1 on 4th REQ cycle, cleared only by `resetn` = 0.
